// File: rtl/s2b_pkg.sv
// Shared types and width helpers for the stochastic-to-binary frame counter.
package s2b_pkg;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  // Counter width holding 0..2**log_len inclusive; result width is one more.
  function automatic int cnt_w(input int log_len);
    return log_len + 1;
  endfunction

endpackage

// File: rtl/u_en_upcnt.sv
// Enable/clear up-counter of width W with asynchronous active-low reset.
module u_en_upcnt #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/u_s2b_frame_cnt.sv
// Counts ones in a programmable-length frame of a unary stream; valid/ready result.
// Define S2B_BIPOLAR_EN for a signed result 2*ones - len instead of the raw count.
module u_s2b_frame_cnt
  import s2b_pkg::*;
#(
  parameter int LOG_LEN = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [LOG_LEN:0]    len,
  input  logic                in_bit,
  input  logic                in_valid,
  output logic                busy,
  output logic [LOG_LEN+1:0]  out_cnt,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int CW      = cnt_w(LOG_LEN);
  localparam int OW      = CW + 1;
  localparam int MAX_LEN = 2 ** LOG_LEN;

  state_t          state, state_next;
  logic [CW-1:0]   len_q, len_eff, smp_cnt, one_cnt, one_next;
  logic [OW-1:0]   result;
  logic            start_acc, run, last;

  assign len_eff   = (len > CW'(MAX_LEN)) ? CW'(MAX_LEN) : len;
  assign start_acc = start && (state == IDLE);
  assign run       = (state == RUN);
  assign last      = run && in_valid && (smp_cnt == len_q - CW'(1));
  assign one_next  = one_cnt + CW'(in_bit);
  assign busy      = run;
  assign out_valid = (state == HOLD);

  // The final sample is still in flight on the last cycle, so fold it in here.
`ifdef S2B_BIPOLAR_EN
  assign result = {one_next, 1'b0} - {1'b0, len_q};
`else
  assign result = {1'b0, one_next};
`endif

  u_en_upcnt #(.W(CW)) u_smp_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_acc),
    .en    (run && in_valid),
    .cnt   (smp_cnt)
  );

  u_en_upcnt #(.W(CW)) u_one_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_acc),
    .en    (run && in_valid && in_bit),
    .cnt   (one_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_acc) state_next = (len_eff == '0) ? HOLD : RUN;
      RUN:     if (last)      state_next = HOLD;
      HOLD:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q   <= '0;
      out_cnt <= '0;
    end else begin
      if (start_acc) len_q <= len_eff;
      if (start_acc && (len_eff == '0)) out_cnt <= '0;
      else if (last)                    out_cnt <= result;
    end
  end

  a_len_legal: assert property (@(posedge clk) disable iff (!rst_n)
    start_acc |-> (len <= CW'(MAX_LEN)));

endmodule
